// File: rtl/gray_rx_monitor_if.sv
// Upstream Gray counter bus: count value plus its "count is zero" wrap flag.
interface gray_rx_monitor_if #(
    parameter int unsigned CBITS = 8
) ();
    logic [CBITS-1:0] gray_in;
    logic             wrap_in;

    modport master (output gray_in, output wrap_in);
    modport slave  (input  gray_in, input  wrap_in);
endinterface

// File: rtl/gray_rx_monitor.sv
// Resynchronises an upstream Gray counter, decodes it to binary and checks that
// it advances by at most one code per cycle; counts wraps and sequence errors.
module gray_rx_monitor #(
    parameter int unsigned CBITS       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERR_LIMIT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    gray_rx_monitor_if.slave  up,
    output logic [CBITS-1:0]  bin_out,
    output logic              bin_valid,
    output logic [15:0]       wrap_cnt,
    output logic [3:0]        err_cnt,
    output logic              fault,
    output logic [1:0]        state
);
    localparam int unsigned ERR_W  = 4;
    localparam int unsigned WRAP_W = 16;
    localparam int unsigned VLD_W  = SYNC_STAGES + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_LIM = ERR_W'(ERR_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        FAULT   = 2'd3
    } state_e;

    logic [CBITS-1:0]       gray_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] wrap_sync_q;
    logic [VLD_W-1:0]       vld_q;
    logic [CBITS-1:0]       gray_s;
    logic                   wrap_s;
    logic [CBITS-1:0]       bin_c;
    logic [CBITS-1:0]       dec_q;
    logic                   wrap_q;
    logic                   zero_q;

    state_e                 state_q;
    logic [CBITS-1:0]       bin_q;
    logic                   valid_q;
    logic [WRAP_W-1:0]      wrap_cnt_q;
    logic [ERR_W-1:0]       err_cnt_q;
    logic                   fault_q;
    logic [CBITS-1:0]       prev_q;

    logic [CBITS-1:0]       delta_c;
    logic                   err_c;
    logic                   wrap_evt_c;
    logic [ERR_W-1:0]       err_inc_c;

    assign gray_s = gray_sync_q[SYNC_STAGES-1];
    assign wrap_s = wrap_sync_q[SYNC_STAGES-1];

    // Equal-depth chains keep count and wrap flag aligned; vld_q marks when
    // the pipeline holds real samples rather than reset contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) gray_sync_q[i] <= '0;
            wrap_sync_q <= '0;
            vld_q       <= '0;
            dec_q       <= '0;
            wrap_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            gray_sync_q[0] <= up.gray_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) gray_sync_q[i] <= gray_sync_q[i-1];
            wrap_sync_q <= SYNC_STAGES'({wrap_sync_q, up.wrap_in});
            vld_q       <= VLD_W'({vld_q, 1'b1});
            dec_q       <= bin_c;
            wrap_q      <= wrap_s;
            zero_q      <= (gray_s == '0);
        end
    end

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_c = '0;
        for (int unsigned i = 0; i < CBITS; i++) bin_c[i] = ^(gray_s >> i);
    end

    assign delta_c    = dec_q - prev_q;
    assign err_c      = (delta_c > CBITS'(1)) || (wrap_q != zero_q);
    assign wrap_evt_c = (prev_q == '1) && (dec_q == '0);
    assign err_inc_c  = (err_cnt_q == ERR_MAX) ? ERR_MAX : err_cnt_q + ERR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            valid_q    <= 1'b0;
            wrap_cnt_q <= '0;
            err_cnt_q  <= '0;
            fault_q    <= 1'b0;
            prev_q     <= '0;
        end else if (clr) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            wrap_cnt_q <= '0;
            err_cnt_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (en && vld_q[VLD_W-1]) state_q <= ACQUIRE;
                end
                ACQUIRE: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else begin
                        prev_q  <= dec_q;
                        bin_q   <= dec_q;
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    if (!en) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else begin
                        bin_q   <= dec_q;
                        prev_q  <= dec_q;
                        valid_q <= 1'b1;
                        if (wrap_evt_c) wrap_cnt_q <= wrap_cnt_q + WRAP_W'(1);
                        // One increment per cycle even when both checks fire.
                        if (err_c) begin
                            err_cnt_q <= err_inc_c;
                            if (err_inc_c >= ERR_LIM) begin
                                state_q <= FAULT;
                                fault_q <= 1'b1;
                                valid_q <= 1'b0;
                            end
                        end
                    end
                end
                FAULT: begin
                    fault_q <= 1'b1;
                    valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = valid_q;
    assign wrap_cnt  = wrap_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: doc/gray_rx_monitor.md
Name: gray_rx_monitor

Overview:
Downstream consumer of the free-running Gray-code counter and its wrap pulse (counter output and "count is zero" flag). Resynchronises both into the local clock domain, decodes Gray to binary, and checks that the sequence advances by at most one code per cycle. Counts wraps, counts and limits sequence errors, and raises a sticky fault for the system monitor.

Parameters:
CBITS, 8, width of incoming Gray count (must match upstream counter width)
SYNC_STAGES, 2, synchroniser depth on gray_in and wrap_in (legal 1..4)
ERR_LIMIT, 3, number of sequence errors that forces FAULT (legal 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  monitor enable; low returns FSM to IDLE (except from FAULT)
clr  in  1  synchronous clear of counters, fault and FSM
gray_in  in  CBITS  Gray count from upstream counter
wrap_in  in  1  upstream wrap flag, high while upstream count is zero
bin_out  out  CBITS  decoded binary count
bin_valid  out  1  high when bin_out holds a checked sample (TRACK only)
wrap_cnt  out  16  number of detected wraps, modulo 2^16
err_cnt  out  4  sequence/consistency errors, saturates at 15
fault  out  1  sticky, high in FAULT
state  out  2  IDLE=0, ACQUIRE=1, TRACK=2, FAULT=3

Behaviour:
- Reset (async): sync chains 0, bin_out 0, bin_valid 0, wrap_cnt 0, err_cnt 0, fault 0, state IDLE, prev 0.
- Sync: gray_in and wrap_in each pass through SYNC_STAGES flops, same depth, so they stay aligned. gray_s and wrap_s are the chain outputs.
- Decode (combinational on gray_s): bin[CBITS-1] = g[CBITS-1]; bin[i] = bin[i+1] ^ g[i].
- Latency: gray_in sampled at edge n appears on bin_out after edge n+SYNC_STAGES+1.
- FSM:
  - IDLE: bin_valid 0. If en=1, go to ACQUIRE.
  - ACQUIRE: prev <= decoded value, bin_out <= decoded value, no check. Next state TRACK. If en=0, go to IDLE.
  - TRACK: bin_valid 1, bin_out <= decoded value every cycle. delta = (decoded - prev) mod 2^CBITS.
    - delta 0: stall; legal, no action.
    - delta 1: legal advance.
    - delta >1: error. err_cnt +1 (saturating), prev realigns to the decoded value, no wrap counted.
    - Consistency: wrap_s != (gray_s == 0) is an error. At most one err_cnt increment per cycle, even if both errors occur.
    - Wrap: prev = 2^CBITS-1 and decoded = 0 increments wrap_cnt (mod 2^16).
    - When err_cnt would reach ERR_LIMIT, go to FAULT on the same edge.
    - If en=0, go to IDLE.
  - FAULT: fault 1, bin_valid 0, counters frozen, en ignored. Exit only via clr or rst.
- clr=1: next edge sets wrap_cnt 0, err_cnt 0, fault 0, bin_valid 0, state IDLE. clr has priority over all FSM transitions. Sync chains are not cleared.
- en low in TRACK/ACQUIRE: wrap_cnt and err_cnt hold; bin_out holds its last value.
- Reset mid-TRACK: all outputs return to reset values immediately (async). After release, ACQUIRE runs before any check, so the first sample is never an error.
- CBITS=1: delta 1 every cycle is legal; every transition 1->0 is a wrap.

Test Plan:
1. Reset then en=1, drive the upstream CBITS=8 counter sequence from 0 -> bin_valid rises 1 cycle after ACQUIRE. bin_out tracks binary 1,2,3... delayed SYNC_STAGES+1 cycles. err_cnt stays 0.
2. Run 600 cycles from binary 0 -> wrap_cnt = 2 (wraps at 256 and 512). wrap_s and gray_s==0 coincide, err_cnt stays 0.
3. In TRACK, force gray_in from Gray(10) to Gray(13) -> err_cnt 1 one cycle later, prev realigns, next step to Gray(14) is legal.
4. Hold gray_in = Gray(0) with wrap_in = 0 for 3 cycles (ERR_LIMIT=3) -> err_cnt 1,2,3 on consecutive cycles. State becomes FAULT, fault=1, bin_valid=0. Toggling en has no effect.
5. From FAULT, pulse clr one cycle -> next edge: fault 0, err_cnt 0, wrap_cnt 0, state IDLE. With en=1: ACQUIRE, then TRACK.
6. Assert rst asynchronously mid-TRACK (between edges) -> all outputs 0 and state IDLE before the next edge. After release with en=1, the first decoded sample causes no error regardless of value.
